// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter that feeds the 32-to-5 bus select encoder.
// It issues a registered one-hot or all-zero grant, with an optional hold limit that preempts the owner.
module bus_grant_arbiter #(
   parameter int N        = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         busy,
   output logic         preempt
);

   localparam int PW = $clog2(N);
   localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t          state_r, state_s;
   logic [N-1:0]    grant_r, grant_s;
   logic [PW-1:0]   owner_r, owner_s;
   logic [PW-1:0]   ptr_r, ptr_s;
   logic [HW-1:0]   hold_r, hold_s;
   logic            busy_r;
   logic            preempt_r, preempt_s;
   logic [PW-1:0]   sel_s;
   logic [PW-1:0]   idx_s;
   logic            found_s;

   function automatic logic [N-1:0] onehot(input logic [PW-1:0] k);
      logic [N-1:0] v;
      v    = {N{1'b0}};
      v[k] = 1'b1;
      return v;
   endfunction

   // Rotating-priority scan: first requester at or after ptr, wrapping past the top bit.
   always_comb begin
      sel_s   = {PW{1'b0}};
      idx_s   = {PW{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx_s = ptr_r + PW'(i);
         if (!found_s && req[idx_s]) begin
            found_s = 1'b1;
            sel_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state logic: grant, release, hold-limit preemption and hold counting.
   always_comb begin
      state_s   = state_r;
      grant_s   = grant_r;
      owner_s   = owner_r;
      ptr_s     = ptr_r;
      hold_s    = hold_r;
      preempt_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_s = OWN;
               owner_s = sel_s;
               grant_s = onehot(sel_s);
               hold_s  = HW'(1);
            end else begin
               grant_s = {N{1'b0}};
            end
         end
         OWN: begin
            // Release outranks preemption, so a departing owner never raises preempt.
            if (!req[owner_r]) begin
               state_s = IDLE;
               grant_s = {N{1'b0}};
               ptr_s   = owner_r + {{(PW-1){1'b0}}, 1'b1};
               hold_s  = {HW{1'b0}};
            end else if ((MAX_HOLD != 0) && (hold_r == HOLD_LIM) &&
                         ((req & ~grant_r) != {N{1'b0}})) begin
               state_s   = IDLE;
               grant_s   = {N{1'b0}};
               ptr_s     = owner_r + {{(PW-1){1'b0}}, 1'b1};
               hold_s    = {HW{1'b0}};
               preempt_s = 1'b1;
            end else if (hold_r >= HOLD_LIM) begin
               hold_s = HOLD_LIM;
            end else begin
               hold_s = hold_r + HW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            grant_s = {N{1'b0}};
            hold_s  = {HW{1'b0}};
         end
      endcase
   end

   // State registers; en=0 freezes everything except the preempt pulse, which always clears.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_r   <= IDLE;
         grant_r   <= {N{1'b0}};
         owner_r   <= {PW{1'b0}};
         ptr_r     <= {PW{1'b0}};
         hold_r    <= {HW{1'b0}};
         busy_r    <= 1'b0;
         preempt_r <= 1'b0;
      end else if (en) begin
         state_r   <= state_s;
         grant_r   <= grant_s;
         owner_r   <= owner_s;
         ptr_r     <= ptr_s;
         hold_r    <= hold_s;
         busy_r    <= (grant_s != {N{1'b0}});
         preempt_r <= preempt_s;
      end else begin
         preempt_r <= 1'b0;
      end
   end

   assign grant   = grant_r;
   assign busy    = busy_r;
   assign preempt = preempt_r;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed bench for bus_grant_arbiter (MAX_HOLD=4), plus a randomized
// reference-model run on a second instance built with MAX_HOLD=2.
module tb_bus_grant_arbiter;

   logic        clk;
   logic        clr, en;
   logic [31:0] req;
   logic [31:0] grant;
   logic        busy, preempt;

   logic        clr2, en2;
   logic [31:0] req2;
   logic [31:0] grant2;
   logic        busy2, preempt2;

   int          checks;
   int          errors;

   logic [31:0] m_grant;
   logic [4:0]  m_ptr, m_own, m_idx;
   int          m_hold;
   logic        m_pre, m_found;

   bus_grant_arbiter #(.N(32), .MAX_HOLD(4)) u_dut (
      .clk(clk), .clr(clr), .en(en), .req(req),
      .grant(grant), .busy(busy), .preempt(preempt)
   );

   bus_grant_arbiter #(.N(32), .MAX_HOLD(2)) u_dut2 (
      .clk(clk), .clr(clr2), .en(en2), .req(req2),
      .grant(grant2), .busy(busy2), .preempt(preempt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      #1;
      clr = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      en = 1'b1; req = 32'h0; clr = 1'b1;
      en2 = 1'b0; req2 = 32'h0; clr2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_grant", grant, 32'h0);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_preempt", {31'h0, preempt}, 32'h0);
      clr = 1'b0;
      clr2 = 1'b0;

      // Asynchronous reset mid-grant
      req = 32'h0000_0003;
      tick();
      chk("pre_clr_grant", grant, 32'h0000_0001);
      clr = 1'b1;
      #1;
      chk("async_clr_grant", grant, 32'h0);
      chk("async_clr_busy", {31'h0, busy}, 32'h0);
      chk("async_clr_preempt", {31'h0, preempt}, 32'h0);
      #1;
      clr = 1'b0;
      tick();
      chk("post_clr_grant", grant, 32'h0000_0001);
      req = 32'h0;
      tick();
      chk("release_grant", grant, 32'h0);

      // Basic rotation
      pulse_clr();
      req = 32'h0000_0012;
      tick();
      chk("rot_e1", grant, 32'h0000_0002);
      chk("rot_e1_busy", {31'h0, busy}, 32'h1);
      req = 32'h0000_0010;
      tick();
      chk("rot_e2_bubble", grant, 32'h0);
      chk("rot_e2_busy", {31'h0, busy}, 32'h0);
      tick();
      chk("rot_e3", grant, 32'h0000_0010);
      req = 32'h0;
      tick();
      chk("rot_release", grant, 32'h0);

      // Preempt with wrap past bit 31
      pulse_clr();
      req = 32'h8000_0000;
      tick();
      chk("pre_own31", grant, 32'h8000_0000);
      req = 32'h8000_0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pre_hold", grant, 32'h8000_0000);
         chk("pre_hold_nopre", {31'h0, preempt}, 32'h0);
      end
      tick();
      chk("pre_revoke_grant", grant, 32'h0);
      chk("pre_revoke_pulse", {31'h0, preempt}, 32'h1);
      tick();
      chk("pre_wrap_grant", grant, 32'h0000_0001);
      chk("pre_pulse_clear", {31'h0, preempt}, 32'h0);

      // Release and preempt condition on the same edge: release wins
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rvp_hold", grant, 32'h0000_0001);
      end
      req = 32'h8000_0000;
      tick();
      chk("rvp_grant", grant, 32'h0);
      chk("rvp_nopreempt", {31'h0, preempt}, 32'h0);
      tick();
      chk("rvp_next", grant, 32'h8000_0000);
      req = 32'h0;
      tick();
      chk("rvp_release", grant, 32'h0);

      // Sole requester is never preempted
      pulse_clr();
      req = 32'h0000_0100;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("sole_grant", grant, 32'h0000_0100);
         chk("sole_nopreempt", {31'h0, preempt}, 32'h0);
      end
      req = 32'h0;
      tick();
      chk("sole_release", grant, 32'h0);

      // Enable freeze
      pulse_clr();
      req = 32'h0000_0004;
      tick();
      chk("frz_grant", grant, 32'h0000_0004);
      en = 1'b0;
      req = 32'h0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("frz_hold", grant, 32'h0000_0004);
         chk("frz_busy", {31'h0, busy}, 32'h1);
      end
      en = 1'b1;
      tick();
      chk("frz_resume", grant, 32'h0);

      // Randomized run on the MAX_HOLD=2 instance against a reference model
      m_grant = 32'h0; m_ptr = 5'd0; m_own = 5'd0; m_hold = 0; m_pre = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         req2 = $urandom & $urandom & $urandom;
         if ($urandom_range(0, 3) == 0) req2 = 32'h0;
         if ((m_grant != 32'h0) && ($urandom_range(0, 3) != 0)) req2 = req2 | m_grant;
         en2 = ($urandom_range(0, 3) != 0);
         m_pre = 1'b0;
         if (en2) begin
            if (m_grant == 32'h0) begin
               m_found = 1'b0;
               for (int i = 0; i < 32; i++) begin
                  m_idx = m_ptr + 5'(i);
                  if (!m_found && req2[m_idx]) begin
                     m_found = 1'b1;
                     m_own = m_idx;
                     m_grant = 32'h1 << m_idx;
                     m_hold = 1;
                  end
               end
            end else if (!req2[m_own]) begin
               m_grant = 32'h0; m_ptr = m_own + 5'd1; m_hold = 0;
            end else if ((m_hold == 2) && ((req2 & ~m_grant) != 32'h0)) begin
               m_grant = 32'h0; m_ptr = m_own + 5'd1; m_hold = 0; m_pre = 1'b1;
            end else if (m_hold < 2) begin
               m_hold = m_hold + 1;
            end
         end
         tick();
         chk("rnd_grant", grant2, m_grant);
         chk("rnd_busy", {31'h0, busy2}, {31'h0, (m_grant != 32'h0)});
         chk("rnd_preempt", {31'h0, preempt2}, {31'h0, m_pre});
         chk("rnd_onehot", {31'h0, ($countones(grant2) <= 1)}, 32'h1);
         chk("rnd_busy_inv", {31'h0, busy2}, {31'h0, (grant2 != 32'h0)});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
